// File: rtl/parity_pkg.sv
// Shared types and width helper for the parity frame accumulator.
// Optional early frame end is enabled with PARITY_ACC_LAST_EN.
package parity_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int cnt_w(input int data_w, input int beats);
    return $clog2(data_w * beats + 1);
  endfunction

endpackage

// File: rtl/ones_count.sv
// Combinational population count of one input beat.
// Result is wide enough for an all-ones beat.
module ones_count #(
  parameter int DATA_W = 3,
  parameter int PC_W   = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [PC_W-1:0]   cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cnt_o = cnt_o + PC_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/parity_frame_acc.sv
// Frame-wise ones counter with odd/even flags on a held output.
// Define PARITY_ACC_LAST_EN to add the in_last early frame end.
module parity_frame_acc
  import parity_pkg::*;
#(
  parameter int DATA_W      = 3,
  parameter int FRAME_BEATS = 4,
  parameter int CNT_W       = cnt_w(DATA_W, FRAME_BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef PARITY_ACC_LAST_EN
  input  logic              in_last,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_odd,
  output logic              out_even
);

  localparam int PC_W   = $clog2(DATA_W + 1);
  localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               odd_q, odd_d;
  logic               even_q, even_d;

  logic [PC_W-1:0]    pc;
  logic [CNT_W-1:0]   sum;
  logic               last_beat;
  logic               frame_end;

  ones_count #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_pc (
    .data_i (in_data),
    .cnt_o  (pc)
  );

`ifdef PARITY_ACC_LAST_EN
  assign last_beat = in_last;
`else
  assign last_beat = 1'b0;
`endif

  // sum includes the current beat so the final beat lands in the result
  assign sum       = acc_q + CNT_W'(pc);
  assign frame_end = (beat_q == BEAT_W'(FRAME_BEATS - 1)) || last_beat;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    even_d  = even_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (frame_end) begin
            cnt_d   = sum;
            odd_d   = sum[0];
            even_d  = !sum[0] && (sum != '0);
            acc_d   = '0;
            beat_d  = '0;
            state_d = HOLD;
          end else begin
            acc_d  = sum;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      odd_q   <= 1'b0;
      even_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      even_q  <= even_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_count = cnt_q;
  assign out_odd   = odd_q;
  assign out_even  = even_q;

endmodule

// File: tb/tb_parity_frame_acc.sv
// Directed and random checks of parity_frame_acc against a frame model.
// Build with PARITY_ACC_LAST_EN to also exercise in_last.
module tb_parity_frame_acc;

  localparam int DW = 3;
  localparam int FB = 4;
  localparam int CW = $clog2(DW * FB + 1);
`ifdef PARITY_ACC_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_count;
  logic          out_odd;
  logic          out_even;

  int n_checks = 0;
  int n_fail   = 0;

  int m_acc   = 0;
  int m_beats = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  parity_frame_acc #(
    .DATA_W      (DW),
    .FRAME_BEATS (FB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef PARITY_ACC_LAST_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_odd   (out_odd),
    .out_even  (out_even)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: tally ones, close the frame on the beat limit or in_last
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        check("sb_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          int e;
          e = exp_q.pop_front();
          check("sb_count", int'(out_count), e);
          check("sb_odd", int'(out_odd), e % 2);
          check("sb_even", int'(out_even), int'(e % 2 == 0 && e != 0));
        end
      end
      if (in_valid && in_ready) begin
        m_acc += $countones(in_data);
        m_beats++;
        if (m_beats == FB || (LAST_EN && in_last)) begin
          exp_q.push_back(m_acc);
          m_acc = 0;
          m_beats = 0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", int'(acc), 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_acc = 0;
    m_beats = 0;
    exp_q.delete();
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_count", int'(out_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] pat[4];
    logic took;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(out_valid), 0);
    check("reset_ready", int'(in_ready), 1);
    check("reset_count", int'(out_count), 0);
    check("reset_odd", int'(out_odd), 0);
    check("reset_even", int'(out_even), 0);
    rst_n = 1'b1;
    idle(1);

    // Basic frame, latency and single-cycle bubble
    pat = '{3'b111, 3'b001, 3'b000, 3'b010};
    out_ready = 1'b1;
    foreach (pat[i]) send(pat[i], 1'b0);
    check("t1_valid", int'(out_valid), 1);
    check("t1_count", int'(out_count), 5);
    check("t1_odd", int'(out_odd), 1);
    check("t1_even", int'(out_even), 0);
    check("t1_ready_lo", int'(in_ready), 0);
    idle(1);
    check("t1_ready_hi", int'(in_ready), 1);
    check("t1_valid_lo", int'(out_valid), 0);
    check("t1_count_kept", int'(out_count), 5);

    // All-zero frame
    repeat (FB) send(3'b000, 1'b0);
    check("t2_count", int'(out_count), 0);
    check("t2_odd", int'(out_odd), 0);
    check("t2_even", int'(out_even), 0);
    idle(1);

    // Back-pressure in HOLD
    pat = '{3'b110, 3'b101, 3'b011, 3'b111};
    out_ready = 1'b0;
    foreach (pat[i]) send(pat[i], 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("t3_valid", int'(out_valid), 1);
      check("t3_count", int'(out_count), 9);
      check("t3_odd", int'(out_odd), 1);
      check("t3_ready", int'(in_ready), 0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    check("t3_released", int'(out_valid), 0);
    check("t3_ready_back", int'(in_ready), 1);

    // Reset mid-frame discards the partial frame
    repeat (2) send(3'b111, 1'b0);
    do_reset();
    repeat (FB) send(3'b001, 1'b0);
    check("t4_count", int'(out_count), 4);
    check("t4_even", int'(out_even), 1);
    check("t4_odd", int'(out_odd), 0);
    idle(1);

    // Reset in HOLD drops the pending result
    out_ready = 1'b0;
    repeat (FB) send(3'b011, 1'b0);
    check("t5_hold", int'(out_valid), 1);
    do_reset();
    out_ready = 1'b1;
    idle(1);

    // Idle gaps between beats
    pat = '{3'b111, 3'b001, 3'b000, 3'b010};
    foreach (pat[i]) begin
      idle($urandom_range(1, 3));
      send(pat[i], 1'b0);
    end
    check("t6_count", int'(out_count), 5);
    check("t6_odd", int'(out_odd), 1);
    idle(1);

`ifdef PARITY_ACC_LAST_EN
    send(3'b011, 1'b0);
    send(3'b010, 1'b1);
    check("t7_count", int'(out_count), 3);
    check("t7_odd", int'(out_odd), 1);
    idle(1);
    repeat (FB) send(3'b111, 1'b0);
    check("t7_full", int'(out_count), 12);
    check("t7_even", int'(out_even), 1);
    idle(1);
`endif

    // Random traffic against the frame model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = DW'($urandom);
        in_last  = ($urandom_range(0, 4) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
